// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: packet byte layout and FIFO sizing.
// Header byte is {payload_len[7:2], dest_addr[1:0]}.
package router_pkg;

  localparam int DATA_W       = 8;
  localparam int FIFO_DEPTH   = 16;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int PKT_CNT_W    = 7;

  // Pointer width including the wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Bytes still to come after a header: payload plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] pkt_len(input logic [DATA_W-1:0] hdr);
    return PKT_CNT_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for router_out_fifo: synchronous write, asynchronous read.
// No reset; contents are only observable through the owning FIFO's pointers.
module router_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_out_fifo.sv
// Per-destination output buffer of the 1x3 router; 1-cycle registered read.
// Writes are dropped while full, reads ignored while empty; tracks packet ends.
module router_out_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int DEPTH  = router_pkg::FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_last,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PKT_CNT_W-1:0] pkt_count;
  logic [DATA_W:0]      rd_entry;
  logic                 clear;
  logic                 do_wr;
  logic                 do_rd;

  assign clear = reset || soft_reset;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Both sides gate on the pre-edge flags, so full+read frees a slot only next cycle.
  assign do_wr = write_enb && !full && !clear;
  assign do_rd = read_enb && !empty && !clear;

  router_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clock  (clock),
    .wr_en  (do_wr),
    .wr_addr(wr_ptr[ADDR_W-1:0]),
    .wr_data({lfd_state, data_in}),
    .rd_addr(rd_ptr[ADDR_W-1:0]),
    .rd_data(rd_entry)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
    end else if (do_wr) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rd_ptr   <= '0;
      data_out <= '0;
    end else if (do_rd) begin
      rd_ptr   <= rd_ptr + PTR_W'(1);
      data_out <= rd_entry[DATA_W-1:0];
    end
  end

  // Header loads the remaining byte count; the byte that takes it from 1 to 0 is parity.
  always_ff @(posedge clock) begin
    if (clear) begin
      pkt_count <= '0;
      rd_last   <= 1'b0;
    end else if (do_rd) begin
      if (rd_entry[DATA_W]) begin
        pkt_count <= pkt_len(rd_entry[DATA_W-1:0]);
        rd_last   <= 1'b0;
      end else if (pkt_count > PKT_CNT_W'(1)) begin
        pkt_count <= pkt_count - PKT_CNT_W'(1);
        rd_last   <= 1'b0;
      end else if (pkt_count == PKT_CNT_W'(1)) begin
        pkt_count <= '0;
        rd_last   <= 1'b1;
      end else begin
        pkt_count <= '0;
        rd_last   <= 1'b0;
      end
    end else begin
      rd_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_out_fifo.sv
// Directed bench for router_out_fifo: reset, packet framing, full/empty edges,
// simultaneous access, soft reset mid-packet and pointer wrap.
module tb_router_out_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read_enb = 1'b0;
  logic [7:0] data_out;
  logic       rd_last;
  logic       full;
  logic       empty;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model_q[$];

  always #5 clock = ~clock;

  router_out_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .rd_last   (rd_last),
    .full      (full),
    .empty     (empty)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int occ();
    logic [4:0] d;
    d = dut.wr_ptr - dut.rd_ptr;
    return int'(d);
  endfunction

  // One clock with the given inputs; inputs return idle and outputs are sampled 1ns after the edge.
  task automatic step(input logic we, input logic lfd, input logic [7:0] d,
                      input logic re, input logic sr);
    write_enb  = we;
    lfd_state  = lfd;
    data_in    = d;
    read_enb   = re;
    soft_reset = sr;
    @(posedge clock);
    #1;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    read_enb   = 1'b0;
    soft_reset = 1'b0;
  endtask

  task automatic push(input logic lfd, input logic [7:0] d);
    step(1'b1, lfd, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] pkt[5];
    logic [7:0] exp_b;
    pkt[0] = 8'h0E; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h3C;

    // 1: reset with write_enb held
    reset = 1'b1;
    write_enb = 1'b1;
    data_in = 8'hAA;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    write_enb = 1'b0;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_data", int'(data_out), 8'h00);
    chk("rst_last", int'(rd_last), 0);
    chk("rst_occ", occ(), 0);

    // 2: one packet, header len 3 addr 2
    for (int i = 0; i < 5; i++) push(i == 0, pkt[i]);
    chk("pkt_occ", occ(), 5);
    for (int i = 0; i < 5; i++) begin
      pop();
      chk($sformatf("pkt_data%0d", i), int'(data_out), int'(pkt[i]));
      chk($sformatf("pkt_last%0d", i), int'(rd_last), (i == 4) ? 1 : 0);
    end
    chk("pkt_empty", int'(empty), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pkt_last_clr", int'(rd_last), 0);

    // 3: fill to full, drop the 17th, drain in order
    for (int i = 0; i < 16; i++) begin
      push(1'b0, 8'(8'h40 + i));
      if (i == 14) chk("fill_not_full15", int'(full), 0);
    end
    chk("fill_full16", int'(full), 1);
    push(1'b0, 8'hEE);
    chk("fill_full17", int'(full), 1);
    chk("fill_occ17", occ(), 16);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk($sformatf("drain%0d", i), int'(data_out), 8'h40 + i);
      if (i == 0) chk("drain_not_full", int'(full), 0);
      if (i == 14) chk("drain_not_empty", int'(empty), 0);
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_last", int'(rd_last), 0);

    // 4: simultaneous read/write at full and at empty
    for (int i = 0; i < 16; i++) push(1'b0, 8'(8'h80 + i));
    step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    chk("sim_full_data", int'(data_out), 8'h80);
    chk("sim_full_occ", occ(), 15);
    for (int i = 1; i < 16; i++) pop();
    chk("sim_full_tail", int'(data_out), 8'h8F);
    chk("sim_full_empty", int'(empty), 1);
    step(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    chk("sim_empty_occ", occ(), 1);
    chk("sim_empty_hold", int'(data_out), 8'h8F);
    pop();
    chk("sim_empty_data", int'(data_out), 8'h55);
    pop();
    chk("pop_empty_hold", int'(data_out), 8'h55);

    // 5: soft reset mid-packet
    push(1'b1, 8'h0C);
    push(1'b0, 8'hA1);
    push(1'b0, 8'hA2);
    push(1'b0, 8'hA3);
    push(1'b0, 8'h5A);
    push(1'b0, 8'h99);
    pop();
    chk("sr_hdr", int'(data_out), 8'h0C);
    chk("sr_cnt_hdr", int'(dut.pkt_count), 4);
    pop();
    chk("sr_b1", int'(data_out), 8'hA1);
    chk("sr_cnt_b1", int'(dut.pkt_count), 3);
    step(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    chk("sr_empty", int'(empty), 1);
    chk("sr_data", int'(data_out), 8'h00);
    chk("sr_cnt", int'(dut.pkt_count), 0);
    pop();
    chk("sr_pop_empty", int'(empty), 1);
    chk("sr_pop_data", int'(data_out), 8'h00);
    chk("sr_pop_last", int'(rd_last), 0);

    // 6: 40 concurrent push/pop cycles at occupancy 3, wrapping the pointers
    model_q.delete();
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 8'(8'hC0 + i));
      model_q.push_back(8'(8'hC0 + i));
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 8'(8'hD0 + i), 1'b1, 1'b0);
      model_q.push_back(8'(8'hD0 + i));
      exp_b = model_q.pop_front();
      chk($sformatf("wrap_data%0d", i), int'(data_out), int'(exp_b));
      if (full || empty) chk($sformatf("wrap_flags%0d", i), int'({full, empty}), 0);
    end
    chk("wrap_occ", occ(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_pre_empty%0d", i), int'(empty), 0);
      pop();
      exp_b = model_q.pop_front();
      chk($sformatf("wrap_drain%0d", i), int'(data_out), int'(exp_b));
    end
    chk("wrap_empty", int'(empty), 1);
    chk("wrap_full", int'(full), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
